// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter slice.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Smallest digit count whose decimal range covers every bin_w-bit value.
  function automatic int unsigned digits_for(input int unsigned bin_w);
    longint unsigned max_bin;
    longint unsigned lim;
    int unsigned d;
    max_bin = (longint'(1) << bin_w) - 1;
    lim = 10;
    d = 1;
    while (lim - 1 < max_bin) begin
      lim = lim * 10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj3.sv
// Combinational double-dabble nibble corrector: digits of 5 or more get +3.
module bcd_digit_adj3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready handshakes.
// Optional sticky overflow flag: define BIN2BCD_OVF_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj3 u_adj (
      .d (bcd_reg[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BIN2BCD_OVF_EN
  logic ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      bcd_reg <= '0;
`ifdef BIN2BCD_OVF_EN
      ovf_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr  <= bin_in;
            bcd_reg <= '0;
            cnt     <= CNT_W'(BIN_W);
`ifdef BIN2BCD_OVF_EN
            ovf_reg <= 1'b0;
`endif
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Top bit of the corrected digits falls off the register here.
          {bcd_reg, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
`ifdef BIN2BCD_OVF_EN
          if (bcd_adj[BCD_W-1]) ovf_reg <= 1'b1;
`endif
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bcd_out   = bcd_reg;

`ifdef BIN2BCD_OVF_EN
  assign ovf = ovf_reg & (state == DONE);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: 8-bit default instance plus a 10-bit overflow instance.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit / 3-digit instance
  logic        iv8, ir8, ov8, or8, ovf8;
  logic [7:0]  bin8;
  logic [11:0] bcd8;

  // 10-bit / 3-digit instance
  logic        iv10, ir10, ov10, or10, ovf10;
  logic [9:0]  bin10;
  logic [11:0] bcd10;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .bin_in(bin8),
    .out_valid(ov8), .out_ready(or8), .bcd_out(bcd8), .ovf(ovf8)
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (
    .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10), .bin_in(bin10),
    .out_valid(ov10), .out_ready(or10), .bcd_out(bcd10), .ovf(ovf10)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of v, keeping the low three, one nibble each.
  function automatic logic [11:0] ref_bcd(input int unsigned v);
    logic [11:0] r;
    int unsigned x;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
`ifdef BIN2BCD_OVF_EN
    return v > 999;
`else
    return (v > 999) && 1'b0;
`endif
  endfunction

  int unsigned last_accept_t;

  // Full transaction on dut8. noise: junk on in_valid/bin_in while busy.
  // hold: cycles of out_ready=0 in DONE before a one-cycle out_ready pulse.
  task automatic run8(input int unsigned v, input bit noise, input int unsigned hold,
                      input bit chk_gap);
    int k;
    logic [11:0] exp_bcd;
    exp_bcd = ref_bcd(v);
    k = 0;
    while (!ir8 && k < 50) begin @(posedge clk); #1; k++; end
    check("ready_before_accept", 32'(ir8), 32'd1);
    bin8 = 8'(v);
    iv8 = 1'b1;
    @(posedge clk);
    if (chk_gap) check("accept_gap", ($time - last_accept_t) / 10, 32'd10);
    last_accept_t = $time;
    #1;
    iv8 = 1'b0;
    check("busy_after_accept", 32'(ir8), 32'd0);
    k = 0;
    while (!ov8 && k < 40) begin
      if (noise) begin iv8 = 1'($urandom); bin8 = 8'($urandom); end
      @(posedge clk); #1; k++;
    end
    check("latency", 32'(k), 32'd8);
    check("bcd8", 32'(bcd8), 32'(exp_bcd));
    check("ovf8", 32'(ovf8), 32'd0);
    for (int h = 0; h < int'(hold); h++) begin
      if (noise) begin iv8 = 1'($urandom); bin8 = 8'($urandom); end
      @(posedge clk); #1;
      if (h == int'(hold) - 1) begin
        check("hold_valid", 32'(ov8), 32'd1);
        check("hold_bcd", 32'(bcd8), 32'(exp_bcd));
        check("hold_ready", 32'(ir8), 32'd0);
      end
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check("valid_drop", 32'(ov8), 32'd0);
    check("ready_rise", 32'(ir8), 32'd1);
    check("bcd_held", 32'(bcd8), 32'(exp_bcd));
  endtask

  task automatic run10(input int unsigned v);
    int k;
    k = 0;
    while (!ir10 && k < 50) begin @(posedge clk); #1; k++; end
    bin10 = 10'(v);
    iv10 = 1'b1;
    @(posedge clk); #1;
    iv10 = 1'b0;
    k = 0;
    while (!ov10 && k < 40) begin @(posedge clk); #1; k++; end
    check("latency10", 32'(k), 32'd10);
    check("bcd10", 32'(bcd10), 32'(ref_bcd(v)));
    check("ovf10", 32'(ovf10), 32'(ref_ovf(v)));
    or10 = 1'b1;
    @(posedge clk); #1;
    or10 = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    iv8 = 0; or8 = 0; bin8 = '0;
    iv10 = 0; or10 = 0; bin10 = '0;
    last_accept_t = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir8), 32'd1);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_bcd", 32'(bcd8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    check("rst_bcd10", 32'(bcd10), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run8(255, 0, 0, 0);
    run8(0, 0, 0, 0);
    run8(99, 0, 0, 1);
    run8(137, 0, 20, 0);
    check("single_transfer", 32'(ov8), 32'd0);

    // Reset during the 4th SHIFT cycle of 200
    bin8 = 8'd200;
    iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(ir8), 32'd1);
    check("abort_out_valid", 32'(ov8), 32'd0);
    check("abort_bcd", 32'(bcd8), 32'd0);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (ov8) seen++; end
    check("abort_no_result", 32'(seen), 32'd0);

    run8(173, 1, 3, 0);
    for (int i = 0; i < 20; i++)
      run8($urandom_range(255), 1, $urandom_range(3), 0);

    run10(1023);
    run10(999);
    run10(1000);
    for (int i = 0; i < 5; i++) run10($urandom_range(1023));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
